// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweep engine.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_e;

  localparam logic [7:0] MAJ3_MASK = 8'hE8;
  localparam logic [7:0] XOR3_MASK = 8'h96;

  function automatic int tbl_w(input int n);
    return 2 ** n;
  endfunction

  // Settle counter width; a one-cycle settle still needs a 1-bit counter.
  function automatic int cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Loadable down-counter that times how long each vector is held on the block under test.
module settle_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector onto a combinational block, samples its output into a truth table,
// and hands the finished table plus a golden-mask mismatch flag to a valid/ready consumer.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int                     N_IN          = 3,
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [tbl_w(N_IN)-1:0] EXPECTED      = MAJ3_MASK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        drive_vec,
  output logic                   busy,
  output logic [N_IN-1:0]        sample_idx,
  output logic [tbl_w(N_IN)-1:0] table_out,
  output logic                   table_valid,
  input  logic                   table_ready,
  output logic                   mismatch
);

  localparam int               TBL_W    = tbl_w(N_IN);
  localparam int               CNT_W    = cnt_w(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  LAST_VEC = '1;

  sweep_state_e     r_state,     w_state_nxt;
  logic [N_IN-1:0]  r_drive_vec, w_vec_nxt;
  logic [TBL_W-1:0] r_table,     w_table_nxt;
  logic             r_valid,     w_valid_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_mismatch,  w_mismatch_nxt;
  logic [TBL_W-1:0] w_sampled;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

  settle_counter #(
    .W (CNT_W)
  ) u_settle_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Table as it will look once the current vector's result is written in.
  always_comb begin
    w_sampled              = r_table;
    w_sampled[r_drive_vec] = dut_out;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    w_state_nxt    = r_state;
    w_vec_nxt      = r_drive_vec;
    w_table_nxt    = r_table;
    w_valid_nxt    = r_valid;
    w_busy_nxt     = r_busy;
    w_mismatch_nxt = r_mismatch;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SETTLE;
          w_vec_nxt   = '0;
          w_table_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_cnt_load  = 1'b1;
        end
      end
      SETTLE: begin
        if (w_cnt_zero) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        w_table_nxt = w_sampled;
        if (r_drive_vec == LAST_VEC) begin
          w_state_nxt    = DONE;
          w_valid_nxt    = 1'b1;
          w_mismatch_nxt = (w_sampled != EXPECTED);
        end else begin
          w_state_nxt = SETTLE;
          w_vec_nxt   = r_drive_vec + N_IN'(1);
          w_cnt_load  = 1'b1;
        end
      end
      DONE: begin
        if (table_ready) begin
          w_state_nxt    = IDLE;
          w_valid_nxt    = 1'b0;
          w_busy_nxt     = 1'b0;
          w_mismatch_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_drive_vec <= '0;
      r_table     <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drive_vec <= w_vec_nxt;
      r_table     <= w_table_nxt;
      r_valid     <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_mismatch  <= w_mismatch_nxt;
    end
  end

  assign drive_vec   = r_drive_vec;
  assign sample_idx  = r_drive_vec;
  assign table_out   = r_table;
  assign table_valid = r_valid;
  assign busy        = r_busy;
  assign mismatch    = r_mismatch;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: the block under test is modelled as a truth-table lookup; results are
// checked against the expected table and golden-mask comparison by a separate monitor.
module tb_truth_table_sweeper;
  import sweeper_pkg::*;

  localparam int TW   = 8;
  localparam int S0   = 2;
  localparam int S1   = 1;
  localparam int LAT0 = 1 + TW * (S0 + 1);
  localparam int LAT1 = 1 + TW * (S1 + 1);

  typedef struct packed {
    logic [7:0] tbl;
    logic       mm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, ready0, dut_out0, busy0, valid0, mm0;
  logic [2:0] drive_vec0, idx0;
  logic [7:0] table0, func0;
  logic       start1, ready1, dut_out1, busy1, valid1, mm1, lag1;
  logic [2:0] drive_vec1, idx1;
  logic [7:0] table1, func1;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Block under test: combinational for the default instance, one-cycle lag for the fast one.
  assign dut_out0 = func0[drive_vec0];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lag1 <= 1'b0;
    else        lag1 <= func1[drive_vec1];
  end
  assign dut_out1 = lag1;

  truth_table_sweeper u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start0),
    .dut_out     (dut_out0),
    .drive_vec   (drive_vec0),
    .busy        (busy0),
    .sample_idx  (idx0),
    .table_out   (table0),
    .table_valid (valid0),
    .table_ready (ready0),
    .mismatch    (mm0)
  );

  truth_table_sweeper #(
    .SETTLE_CYCLES (S1)
  ) u_dut_s1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .dut_out     (dut_out1),
    .drive_vec   (drive_vec1),
    .busy        (busy1),
    .sample_idx  (idx1),
    .table_out   (table1),
    .table_valid (valid1),
    .table_ready (ready1),
    .mismatch    (mm1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake on the default instance must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && valid0 && ready0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_table", table0, mon_e.tbl);
        check("sb_mismatch", mm0, mon_e.mm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ready_mode: 0 = hold 1, 1 = random, 2 = hold 0. Returns once table_valid is seen.
  task automatic start_and_wait(input logic [7:0] func, input int ready_mode, output bit got);
    exp_t e;
    int   n;
    int   vec_err;
    func0 = func;
    e.tbl = func;
    e.mm  = (func != MAJ3_MASK);
    exp_q.push_back(e);
    start0  = 1'b1;
    n       = 0;
    vec_err = 0;
    got     = 1'b0;
    while (!got && n < 200) begin
      ready0 = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 0);
      tick();
      start0 = 1'b0;
      n++;
      if (valid0) begin
        got = 1'b1;
      end else if (drive_vec0 != 3'((n - 1) / (S0 + 1)) || idx0 != drive_vec0 || !busy0) begin
        vec_err++;
      end
    end
    check("latency", n, LAT0);
    check("vec_sequence_errors", vec_err, 0);
  endtask

  task automatic finish_handshake(input bit rand_ready);
    for (int k = 0; k < 40; k++) begin
      ready0 = (rand_ready && k < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (ready0) break;
    end
    ready0 = 1'b0;
    check("idle_busy", busy0, 0);
    check("idle_valid", valid0, 0);
    check("hold_drive_vec", drive_vec0, 7);
  endtask

  task automatic sweep(input logic [7:0] func, input bit rand_ready);
    bit got;
    start_and_wait(func, rand_ready ? 1 : 0, got);
    if (got) finish_handshake(rand_ready);
  endtask

  task automatic backpressure_test(input logic [7:0] func);
    bit   got;
    int   err;
    logic exp_mm;
    exp_mm = (func != MAJ3_MASK);
    start_and_wait(func, 2, got);
    if (got) begin
      err = 0;
      for (int k = 0; k < 10; k++) begin
        if (valid0 !== 1'b1 || table0 !== func || mm0 !== exp_mm) err++;
        start0 = (k == 4);
        tick();
      end
      start0 = 1'b0;
      check("bp_hold_errors", err, 0);
      ready0 = 1'b1;
      start0 = 1'b1;
      tick();
      ready0 = 1'b0;
      start0 = 1'b0;
      err = 0;
      repeat (40) begin
        if (busy0 || valid0) err++;
        tick();
      end
      check("no_second_sweep", err, 0);
      check("bp_table_kept", table0, func);
    end
  endtask

  task automatic reset_mid_sweep();
    int n;
    bit got;
    start_and_wait_partial: begin
      exp_t e;
      func0 = MAJ3_MASK;
      e.tbl = MAJ3_MASK;
      e.mm  = 1'b0;
      exp_q.push_back(e);
      ready0 = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
    end
    n = 0;
    while (drive_vec0 != 3'd4 && n < 100) begin
      tick();
      n++;
    end
    check("reach_vec4", drive_vec0, 4);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_drive_vec", drive_vec0, 0);
    check("rst_sample_idx", idx0, 0);
    check("rst_table", table0, 0);
    check("rst_busy", busy0, 0);
    check("rst_valid", valid0, 0);
    check("rst_mismatch", mm0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    sweep(MAJ3_MASK, 1'b0);
  endtask

  task automatic sweep_s1(input logic [7:0] func);
    int n;
    bit got;
    func1  = func;
    ready1 = 1'b1;
    tick();
    start1 = 1'b1;
    n      = 0;
    got    = 1'b0;
    while (!got && n < 200) begin
      tick();
      start1 = 1'b0;
      n++;
      if (valid1) got = 1'b1;
    end
    check("s1_latency", n, LAT1);
    check("s1_table", table1, func);
    check("s1_mismatch", mm1, (func != MAJ3_MASK));
    tick();
    check("s1_idle_valid", valid1, 0);
    check("s1_idle_busy", busy1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    start0 = 1'b0; ready0 = 1'b0; func0 = MAJ3_MASK;
    start1 = 1'b0; ready1 = 1'b0; func1 = MAJ3_MASK;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_drive_vec", drive_vec0, 0);
    check("reset_busy", busy0, 0);
    check("reset_valid", valid0, 0);
    check("reset_table", table0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_start", {drive_vec0, busy0, valid0, table0, mm0}, 0);
    end

    sweep(MAJ3_MASK, 1'b0);
    sweep(XOR3_MASK, 1'b0);
    backpressure_test(8'($urandom));
    reset_mid_sweep();
    for (int i = 0; i < 4; i++) begin
      sweep(8'($urandom), 1'b1);
    end
    sweep_s1(MAJ3_MASK);
    sweep_s1(8'($urandom));

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
